ttt_move_entry: RTL
===================

# ttt_move_entry

Input stage of the tic-tac-toe datapath, sitting between the board slide switches and the position decoders / `fsm_controller`. It synchronises and debounces the six raw switch inputs. It converts a deliberate "player flips select switch" gesture into a single one-cycle move command carrying a registered 4-bit position code. This guarantees one decoded enable pulse per physical move instead of a level held for the switch's lifetime.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive post-sync cycles a bit must differ from its stable value before the stable value flips; legal range ≥1.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `sw_raw`  in  6: asynchronous switches.
  - [5:2] position code.
  - [1:0] player select: 01 = P1, 10 = P2.
- `sw_stable`  out  6: debounced switch vector.
- `pos_code`  out  4: position code latched at command issue; holds until next issue.
- `p1_move`  out  1: one-cycle pulse, P1 move with valid `pos_code`.
- `p2_move`  out  1: one-cycle pulse, P2 move with valid `pos_code`.
- `bad_code`  out  1: one-cycle pulse, move gesture with code > 8 (no p1/p2 pulse).
- `armed`  out  1: high while in ARMED (select field reads 00, ready for a move).

## Operation
- Per bit: 2-FF synchroniser, then a debounce counter.
  - Counter clears whenever the synced bit equals the stable bit.
  - Otherwise it increments.
  - When the count reaches `DEBOUNCE_CYCLES`-1 while still differing, the stable bit toggles and the counter clears.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1).
- Move FSM operates only on `sw_stable`.
- States: WAIT_RELEASE, ARMED, ISSUE.
  - WAIT_RELEASE → ARMED when sel==00.
  - ARMED:
    - sel==01 or 10 → ISSUE; `pos_code` ← `sw_stable[5:2]` in that same cycle; player recorded.
    - sel==11 → WAIT_RELEASE, no output.
    - sel==00 → stay.
  - ISSUE (exactly 1 cycle):
    - Code 0–8: assert `p1_move` or `p2_move` per recorded player.
    - Code 9–15: assert `bad_code` instead.
    - Then → WAIT_RELEASE.
- At most one of `p1_move`, `p2_move`, `bad_code` is high in any cycle.
- Switch held at 01/10 issues exactly one command; a new command requires sel to return to 00.
- Position bits changing while sel ≠ 00 have no effect on `pos_code`.
- Simultaneous position and select change: the position value in `sw_stable` on the cycle sel leaves 00 is the one latched.
- Reset values: `sw_stable`=0, counters=0, sync FFs=0, `pos_code`=0, all pulses 0, `armed`=0, state WAIT_RELEASE.
  - Switches up at reset never produce a move until sel has returned to 00.
- Reset mid-operation (including during ISSUE) aborts; the pending pulse is not emitted.

## Timing
- Raw edge → `sw_stable` edge: 2 sync + `DEBOUNCE_CYCLES` cycles, provided the raw level is clean for that window.
- A glitch shorter than `DEBOUNCE_CYCLES` post-sync cycles never reaches `sw_stable`.
- `sw_stable` sel leaving 00 (in ARMED) → command pulse 1 cycle later.
- `pos_code` is valid in the pulse cycle and stays stable afterwards.
- `armed` deasserts the cycle after sel leaves 00.
- All outputs are registered.

## Configuration
- `SW_DEBOUNCE_BYPASS_EN` defined: debounce counters are removed and `sw_stable` = synchroniser output, giving 2-cycle latency. `DEBOUNCE_CYCLES` is ignored. Used for fast system simulation.
- Undefined: full debounce as above.
- FSM behaviour is identical in both builds.

## Structure
- Shared package `ttt_pkg`:
  - select encodings `SEL_NONE`=2'b00, `SEL_P1`=2'b01, `SEL_P2`=2'b10, `SEL_BOTH`=2'b11.
  - `POS_MAX`=4'd8.
  - move-entry state enum.
- Sub-module `sw_debounce` (one bit: synchroniser + counter, parameter `DEBOUNCE_CYCLES`), instantiated 6× via generate.
- FSM and output registers in `ttt_move_entry`.

## Test plan
(Benches use `DEBOUNCE_CYCLES`=4.)
- Reset with `sw_raw`=6'b0101_01 → no pulse ever. Drop sel to 00, wait 6 cycles, set sel=01 → `p1_move` single pulse, `pos_code`=5, 7 cycles after the raw edge.
- From ARMED, raw sel=10 with code 4'd8 → `p2_move` one cycle, `pos_code`=8. Holding sel=10 for 100 cycles gives no further pulse.
- Code 4'd12, sel 00→01 → `bad_code` one cycle; `p1_move`/`p2_move` stay 0; `pos_code`=12.
- From ARMED, raw sel bit pulses 3 cycles then returns to 0 → `sw_stable` unchanged, no pulse, `armed` stays 1.
- From ARMED, sel 00→11 → no pulse. Then 11→01 without passing 00 → no pulse. Then →00→01 → `p1_move` pulse.
- Assert `reset` in the cycle the FSM enters ISSUE → no pulse, all outputs 0 next cycle, state WAIT_RELEASE.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: switch select encodings, highest legal board
// position and the move-entry FSM state type.
package ttt_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  localparam logic [3:0] POS_MAX = 4'd8;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    ARMED        = 2'd1,
    ISSUE        = 2'd2
  } move_state_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchroniser followed by a consecutive-difference debounce
// counter. Defining SW_DEBOUNCE_BYPASS_EN removes the counter (stable = synchroniser).
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic quiet
);

  logic sync_p0, sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN
  assign stable = sync_p1;
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_p2;
  logic             stable_p2;

  // Debounce stage: flip only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p2    <= '0;
      stable_p2 <= 1'b0;
    end else if (sync_p1 == stable_p2) begin
      cnt_p2 <= '0;
    end else if (cnt_p2 == CNT_LAST) begin
      stable_p2 <= ~stable_p2;
      cnt_p2    <= '0;
    end else begin
      cnt_p2 <= cnt_p2 + CNT_W'(1);
    end
  end

  assign stable = stable_p2;
`endif

  // Nothing in flight: the debounced level already matches the synchroniser.
  assign quiet = (sync_p0 == stable) && (sync_p1 == stable);

endmodule

// File: rtl/ttt_move_entry.sv
// Switch input stage: per-bit sync/debounce and a move FSM that turns a select gesture
// into one registered command pulse. SW_DEBOUNCE_BYPASS_EN selects the no-debounce build.
module ttt_move_entry
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sw_raw,
  output logic [5:0] sw_stable,
  output logic [3:0] pos_code,
  output logic       p1_move,
  output logic       p2_move,
  output logic       bad_code,
  output logic       armed
);

  logic [5:0] quiet;

  for (genvar i = 0; i < 6; i++) begin : g_bit
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .quiet  (quiet[i])
    );
  end

  logic [1:0]  sel;
  logic [3:0]  pos_in;
  logic        loaded_q, settled_q;
  move_state_e state_q, state_d;
  logic [3:0]  pos_d;
  logic        p1_d, p2_d, bad_d;

  assign sel    = sw_stable[1:0];
  assign pos_in = sw_stable[5:2];

  // sw_stable reads 0 straight out of reset; arming waits until it has caught up
  // with the real switches so a switch left up at reset cannot look like a release.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_code;
    p1_d    = 1'b0;
    p2_d    = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      WAIT_RELEASE: begin
        if (settled_q && sel == SEL_NONE) state_d = ARMED;
      end
      ARMED: begin
        if (sel == SEL_P1 || sel == SEL_P2) begin
          state_d = ISSUE;
          pos_d   = pos_in;
          if (pos_in > POS_MAX) bad_d = 1'b1;
          else if (sel == SEL_P1) p1_d = 1'b1;
          else p2_d = 1'b1;
        end else if (sel == SEL_BOTH) begin
          state_d = WAIT_RELEASE;
        end
      end
      ISSUE:   state_d = WAIT_RELEASE;
      default: state_d = WAIT_RELEASE;
    endcase
  end

  // Pulses are registered on entry to ISSUE so they coincide with the ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_RELEASE;
      loaded_q  <= 1'b0;
      settled_q <= 1'b0;
      pos_code  <= 4'd0;
      p1_move   <= 1'b0;
      p2_move   <= 1'b0;
      bad_code  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state_q   <= state_d;
      loaded_q  <= 1'b1;
      settled_q <= settled_q | (loaded_q & (&quiet));
      pos_code  <= pos_d;
      p1_move   <= p1_d;
      p2_move   <= p2_d;
      bad_code  <= bad_d;
      armed     <= (state_d == ARMED);
    end
  end

endmodule
